// File: rtl/instr_imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_imm_encoder_if
// Brief    : Request/response handshake bundle for instr_imm_encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_class;
    logic [4:0]  in_rt;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_ovf;

    modport slave (
        input  in_valid, in_class, in_rt, in_rn, in_rm, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_ovf
    );

    modport master (
        output in_valid, in_class, in_rt, in_rn, in_rm, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/instr_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_imm_encoder
// Brief    : LEGv8 LDUR/STUR/CBZ/ADD word packer with immediate-fit detection
//            and a 2-entry output queue. Optional counters: IMM_ENC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_imm_encoder (
    input  wire logic             clk,
    input  wire logic             reset,
    instr_imm_encoder_if.slave    bus
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [15:0]           stat_words,
    output logic [15:0]           stat_ovf
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_head_instr;
    logic        r_head_ovf;
    logic [31:0] r_tail_instr;
    logic        r_tail_ovf;

    logic        w_d_fit;
    logic        w_cb_fit;
    logic [31:0] w_instr;
    logic        w_ovf;
    logic        w_push;
    logic        w_pop;

    // An immediate fits when every bit above the field's sign bit matches it.
    always_comb begin
        w_d_fit  = (&bus.in_imm[63:8])  | ~(|bus.in_imm[63:8]);
        w_cb_fit = (&bus.in_imm[63:18]) | ~(|bus.in_imm[63:18]);
        w_instr  = 32'd0;
        w_ovf    = 1'b0;
        case (bus.in_class)
            2'b00: begin
                w_instr = {11'b11111000010, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
                w_ovf   = ~w_d_fit;
            end
            2'b01: begin
                w_instr = {11'b11111000000, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
                w_ovf   = ~w_d_fit;
            end
            2'b10: begin
                w_instr = {8'b10110100, bus.in_imm[18:0], bus.in_rt};
                w_ovf   = ~w_cb_fit;
            end
            default: begin
                w_instr = {11'b10001011000, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rt};
                w_ovf   = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = (r_state != S_TWO) && !reset;
    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.out_instr = r_head_instr;
    assign bus.out_ovf   = r_head_ovf;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    // Head register is zeroed whenever the queue drains so the output reads 0 when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_head_instr <= 32'd0;
            r_head_ovf   <= 1'b0;
            r_tail_instr <= 32'd0;
            r_tail_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_instr <= w_instr;
                        r_head_ovf   <= w_ovf;
                        r_state      <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_tail_instr <= w_instr;
                            r_tail_ovf   <= w_ovf;
                            r_state      <= S_TWO;
                        end
                        2'b01: begin
                            r_head_instr <= 32'd0;
                            r_head_ovf   <= 1'b0;
                            r_state      <= S_EMPTY;
                        end
                        2'b11: begin
                            r_head_instr <= w_instr;
                            r_head_ovf   <= w_ovf;
                        end
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head_instr <= r_tail_instr;
                        r_head_ovf   <= r_tail_ovf;
                        r_state      <= S_ONE;
                    end
                end
                default: begin
                    r_state      <= S_EMPTY;
                    r_head_instr <= 32'd0;
                    r_head_ovf   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_ENC_STATS_EN
    logic [15:0] r_stat_words;
    logic [15:0] r_stat_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_words <= 16'd0;
            r_stat_ovf   <= 16'd0;
        end else if (w_pop) begin
            r_stat_words <= r_stat_words + 16'd1;
            if (r_head_ovf) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_ovf   = r_stat_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_imm_encoder
// Brief    : Directed and randomized checks of instr_imm_encoder against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_imm_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_imm_encoder_if bus();

`ifdef IMM_ENC_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_ovf;
`endif

    instr_imm_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef IMM_ENC_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_ovf   (stat_ovf)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q[$];
    int          m_words = 0;
    int          m_ovf   = 0;

    // Reference encoding from field arithmetic and signed range tests.
    function automatic logic [32:0] model(input logic [1:0] cls, input logic [4:0] rt,
                                          input logic [4:0] rn, input logic [4:0] rm,
                                          input logic [63:0] imm);
        longint          s;
        longint unsigned f;
        logic [31:0]     w;
        logic            ovf;
        s = $signed(imm);
        case (cls)
            2'd0, 2'd1: begin
                ovf = !(s >= -256 && s <= 255);
                f   = imm % 512;
                w   = ((cls == 2'd0) ? 32'hF8400000 : 32'hF8000000)
                      + 32'(f * 4096) + 32'(rn) * 32 + 32'(rt);
            end
            2'd2: begin
                ovf = !(s >= -262144 && s <= 262143);
                f   = imm % 524288;
                w   = 32'hB4000000 + 32'(f * 32) + 32'(rt);
            end
            default: begin
                ovf = 1'b0;
                w   = 32'h8B000000 + 32'(rm) * 65536 + 32'(rn) * 32 + 32'(rt);
            end
        endcase
        return {ovf, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [32:0] h;
        h = (q.size() != 0) ? q[0] : 33'd0;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("in_ready",  64'(bus.in_ready),  64'(!reset && q.size() < 2));
        chk("out_instr", 64'(bus.out_instr), 64'(h[31:0]));
        chk("out_ovf",   64'(bus.out_ovf),   64'(h[32]));
`ifdef IMM_ENC_STATS_EN
        chk("stat_words", 64'(stat_words), 64'(m_words));
        chk("stat_ovf",   64'(stat_ovf),   64'(m_ovf));
`endif
    endtask

    task automatic cycle();
        bit          acc;
        bit          pop;
        logic [32:0] e;
        acc = bus.in_valid && !reset && (q.size() < 2);
        pop = bus.out_ready && (q.size() != 0);
        e   = model(bus.in_class, bus.in_rt, bus.in_rn, bus.in_rm, bus.in_imm);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            m_words = 0;
            m_ovf   = 0;
        end else begin
            if (pop) begin
                m_words = (m_words + 1) % 65536;
                if (q[0][32]) m_ovf = (m_ovf + 1) % 65536;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        check_state();
    endtask

    task automatic set_req(input logic [1:0] cls, input logic [4:0] rt, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [63:0] imm);
        bus.in_class = cls;
        bus.in_rt    = rt;
        bus.in_rn    = rn;
        bus.in_rm    = rm;
        bus.in_imm   = imm;
    endtask

    task automatic offer(input logic [1:0] cls, input logic [4:0] rt, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [63:0] imm);
        bit done;
        done = 1'b0;
        set_req(cls, rt, rn, rm, imm);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = !reset && (q.size() < 2);
            cycle();
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL offer_timeout: observed not-accepted expected accepted");
        end
    endtask

    function automatic logic [63:0] pick_imm();
        longint v;
        case ($urandom % 10)
            0: v = -256;
            1: v = 255;
            2: v = 256;
            3: v = -257;
            4: v = 262143;
            5: v = -262144;
            6: v = 262144;
            7: v = -262145;
            8: v = {$urandom, $urandom};
            default: v = longint'($urandom_range(0, 1023)) - 512;
        endcase
        return v;
    endfunction

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_req(2'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Single-word encodings with the consumer always ready.
        bus.out_ready = 1'b1;
        offer(2'd0, 5'd2, 5'd1, 5'd0, 64'd3);
        chk("ldur3_instr", 64'(bus.out_instr), 64'h00000000F8403022);
        chk("ldur3_ovf",   64'(bus.out_ovf),   64'd0);
        cycle();
        offer(2'd1, 5'd2, 5'd1, 5'd0, 64'hFFFFFFFFFFFFFFFF);
        chk("stur_m1_instr", 64'(bus.out_instr), 64'h00000000F81FF022);
        chk("stur_m1_ovf",   64'(bus.out_ovf),   64'd0);
        cycle();
        offer(2'd2, 5'd1, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC);
        chk("cbz_m4_instr", 64'(bus.out_instr), 64'h00000000B4FFFF81);
        chk("cbz_m4_ovf",   64'(bus.out_ovf),   64'd0);
        cycle();
        offer(2'd3, 5'd2, 5'd1, 5'd1, 64'd0);
        chk("add_instr", 64'(bus.out_instr), 64'h000000008B010022);
        chk("add_ovf",   64'(bus.out_ovf),   64'd0);
        cycle();
        offer(2'd0, 5'd2, 5'd1, 5'd0, 64'd256);
        chk("ldur256_instr", 64'(bus.out_instr), 64'h00000000F8500022);
        chk("ldur256_ovf",   64'(bus.out_ovf),   64'd1);
        cycle();
`ifdef IMM_ENC_STATS_EN
        chk("stat_ovf_after_pop", 64'(stat_ovf), 64'd1);
`endif

        // Fill under backpressure, then drain in order.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_req(2'd0, 5'd2, 5'd1, 5'd0, 64'd3);
        cycle();
        set_req(2'd1, 5'd2, 5'd1, 5'd0, 64'hFFFFFFFFFFFFFFFF);
        cycle();
        set_req(2'd2, 5'd1, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC);
        cycle();
        cycle();
        chk("full_in_ready",   64'(bus.in_ready),  64'd0);
        chk("full_head_held",  64'(bus.out_instr), 64'h00000000F8403022);
        bus.out_ready = 1'b1;
        cycle();
        chk("drain_second", 64'(bus.out_instr), 64'h00000000F81FF022);
        cycle();
        chk("drain_third",  64'(bus.out_instr), 64'h00000000B4FFFF81);
        bus.in_valid = 1'b0;
        cycle();
        chk("drain_empty",  64'(bus.out_valid), 64'd0);

        // Reset with two words queued discards them.
        bus.out_ready = 1'b0;
        offer(2'd3, 5'd7, 5'd8, 5'd9, 64'd0);
        offer(2'd0, 5'd4, 5'd5, 5'd0, 64'd17);
        reset = 1'b1;
        cycle();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        reset = 1'b0;
        cycle();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) cycle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            reset         = ($urandom % 64) == 0;
            set_req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), pick_imm());
            cycle();
        end
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
